score_keeper: RTL

- Upstream score stage of the LED game; feeds the 7-segment decoder.
- Turns hit/miss button levels into a saturating 2-digit BCD score (00–99).
- Time-multiplexes the two BCD digits onto one 4-bit `points` nibble for the decoder, with matching active-low digit enables.
- Raises `game_won` when the score reaches MAX_SCORE.

---
 rtl/score_keeper_if.sv | 22 ++
 rtl/score_keeper.sv | 107 ++++++++++
 2 files changed

// File: rtl/score_keeper_if.sv
// Score keeper bus: button levels and clear in, score digits and display scan out.
// The master side drives the buttons; the slave side is the score keeper itself.
interface score_keeper_if;
  logic       _hit;
  logic       _miss;
  logic       _clear;
  logic [3:0] points;
  logic [1:0] digit_en;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic       game_won;

  modport master (
    output _hit, _miss, _clear,
    input  points, digit_en, score_tens, score_ones, game_won
  );

  modport slave (
    input  _hit, _miss, _clear,
    output points, digit_en, score_tens, score_ones, game_won
  );
endinterface

// File: rtl/score_keeper.sv
// Saturating 2-digit BCD score with edge-detected hit/miss and a multiplexed digit scan.
// Optional: SCORE_KEEPER_BLANK_LEADING_ZERO_EN blanks the tens digit while it is zero.
module score_keeper #(
  parameter int MAX_SCORE = 99,
  parameter int SCAN_DIV  = 50000,
  parameter int SCAN_W    = 16
) (
  input logic           _clk,
  input logic           _reset,
  score_keeper_if.slave bus
);

  localparam logic [3:0]        MAX_TENS  = 4'(MAX_SCORE / 10);
  localparam logic [3:0]        MAX_ONES  = 4'(MAX_SCORE % 10);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic              hit_q_reg, miss_q_reg;
  logic [3:0]        tens_reg, ones_reg;
  logic [3:0]        tens_next, ones_next;
  logic              won_reg;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic              digit_sel_reg;

  logic hit_edge, miss_edge, at_max, at_zero;

  assign hit_edge  = bus._hit  & ~hit_q_reg;
  assign miss_edge = bus._miss & ~miss_q_reg;
  assign at_max    = (tens_reg == MAX_TENS) && (ones_reg == MAX_ONES);
  assign at_zero   = (tens_reg == 4'd0) && (ones_reg == 4'd0);

  always_comb begin
    tens_next = tens_reg;
    ones_next = ones_reg;
    if (bus._clear) begin
      tens_next = 4'd0;
      ones_next = 4'd0;
    end else if (hit_edge && !miss_edge && !at_max) begin
      if (ones_reg == 4'd9) begin
        ones_next = 4'd0;
        tens_next = tens_reg + 4'd1;
      end else begin
        ones_next = ones_reg + 4'd1;
      end
    end else if (miss_edge && !hit_edge && !at_zero) begin
      if (ones_reg == 4'd0) begin
        ones_next = 4'd9;
        tens_next = tens_reg - 4'd1;
      end else begin
        ones_next = ones_reg - 4'd1;
      end
    end
  end

  // Edge-detect history resets high so a button held through reset needs a fresh press.
  always_ff @(posedge _clk or posedge _reset) begin
    if (_reset) begin
      hit_q_reg  <= 1'b1;
      miss_q_reg <= 1'b1;
      tens_reg   <= 4'd0;
      ones_reg   <= 4'd0;
      won_reg    <= 1'b0;
    end else begin
      hit_q_reg  <= bus._hit;
      miss_q_reg <= bus._miss;
      tens_reg   <= tens_next;
      ones_reg   <= ones_next;
      won_reg    <= (tens_next == MAX_TENS) && (ones_next == MAX_ONES);
    end
  end

  always_ff @(posedge _clk or posedge _reset) begin
    if (_reset) begin
      scan_cnt_reg  <= '0;
      digit_sel_reg <= 1'b0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg  <= '0;
      digit_sel_reg <= ~digit_sel_reg;
    end else begin
      scan_cnt_reg  <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  logic [3:0] points_mux;
  logic [1:0] digit_en_mux;

  always_comb begin
    points_mux   = ones_reg;
    digit_en_mux = 2'b10;
    if (digit_sel_reg) begin
      points_mux   = tens_reg;
      digit_en_mux = 2'b01;
`ifdef SCORE_KEEPER_BLANK_LEADING_ZERO_EN
      if (tens_reg == 4'd0) begin
        points_mux   = 4'd0;
        digit_en_mux = 2'b11;
      end
`endif
    end
  end

  assign bus.points     = points_mux;
  assign bus.digit_en   = digit_en_mux;
  assign bus.score_tens = tens_reg;
  assign bus.score_ones = ones_reg;
  assign bus.game_won   = won_reg;

endmodule
